// File: rtl/sobel_pkg.sv
// Shared widths, pipeline stage payloads and frame sizing for the Sobel blocks.
package sobel_pkg;
  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int ABS_W  = 10;
  localparam int SUM_W  = 11;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [ABS_W-1:0]         abs_t;
  typedef logic [SUM_W-1:0]         sum_t;

  typedef struct packed {
    grad_t gx;
    grad_t gy;
    pix_t  th;
  } s1_t;

  typedef struct packed {
    abs_t ax;
    abs_t ay;
    pix_t th;
  } s2_t;

  typedef struct packed {
    pix_t mag;
    logic edg;
  } s3_t;

  // Interior pixel count: the 3x3 window never centres on the border.
  function automatic int frame_pixels(input int rows, input int cols);
    return (rows - 2) * (cols - 2);
  endfunction
endpackage

// File: rtl/sobel_gradient_if.sv
// Window-in / gradient-out bundle between the data buffer, sobel_gradient and its consumer.
interface sobel_gradient_if;
  import sobel_pkg::*;

  logic valid_i;
  pix_t d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i;
  pix_t thresh_i;
  pix_t mag_o;
  logic edge_o;
  logic valid_o;
  logic done_o;

  modport master (
    output valid_i, d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i, thresh_i,
    input  mag_o, edge_o, valid_o, done_o
  );

  modport slave (
    input  valid_i, d0_i, d1_i, d2_i, d3_i, d4_i, d5_i, d6_i, d7_i, d8_i, thresh_i,
    output mag_o, edge_o, valid_o, done_o
  );
endinterface

// File: rtl/sobel_kernel3.sv
// Combinational Sobel Gx/Gy over a row-major 3x3 window (win_i[0] top-left, win_i[8] bottom-right).
module sobel_kernel3 #(
  parameter int W = 8
) (
  input  logic [8:0][W-1:0] win_i,
  output logic signed [W+2:0] gx_o,
  output logic signed [W+2:0] gy_o
);
  localparam int GW = W + 3;

  logic [GW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

  // a + 2b + c, wide enough that the subtraction below cannot overflow
  function automatic logic [GW-1:0] wsum(input logic [W-1:0] a, b, c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  always_comb begin
    gx_pos = wsum(win_i[2], win_i[5], win_i[8]);
    gx_neg = wsum(win_i[0], win_i[3], win_i[6]);
    gy_pos = wsum(win_i[6], win_i[7], win_i[8]);
    gy_neg = wsum(win_i[0], win_i[1], win_i[2]);
    gx_o   = $signed(gx_pos - gx_neg);
    gy_o   = $signed(gy_pos - gy_neg);
  end
endmodule

// File: rtl/sobel_gradient.sv
// Three-stage Sobel magnitude + edge flag pipeline with an interior-pixel frame counter.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int ROWS   = 5,
  parameter int COLS   = 6,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  sobel_gradient_if.slave bus
);
  localparam int STAGES = 3;
  localparam int FRAME  = frame_pixels(ROWS, COLS);
  localparam int CNT_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

  logic [8:0][DATA_W-1:0]  win;
  logic signed [DATA_W+2:0] gx, gy;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  sum_t sum;
  pix_t mag_sat;

  assign win = {bus.d8_i, bus.d7_i, bus.d6_i, bus.d5_i, bus.d4_i,
                bus.d3_i, bus.d2_i, bus.d1_i, bus.d0_i};

  sobel_kernel3 #(.W(DATA_W)) u_kernel (
    .win_i (win),
    .gx_o  (gx),
    .gy_o  (gy)
  );

  // Each data stage only loads when its own valid bit does, so bubbles leave it untouched.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.valid_i};

    s1_d = s1_q;
    if (bus.valid_i) begin
      s1_d.gx = gx;
      s1_d.gy = gy;
      s1_d.th = bus.thresh_i;
    end

    s2_d = s2_q;
    if (vld_pipe_q[1]) begin
      s2_d.ax = ABS_W'(s1_q.gx[GRAD_W-1] ? -s1_q.gx : s1_q.gx);
      s2_d.ay = ABS_W'(s1_q.gy[GRAD_W-1] ? -s1_q.gy : s1_q.gy);
      s2_d.th = s1_q.th;
    end

    sum     = SUM_W'(s2_q.ax) + SUM_W'(s2_q.ay);
    mag_sat = (sum > SUM_W'(PIX_MAX)) ? PIX_MAX : sum[PIX_W-1:0];
    s3_d = s3_q;
    if (vld_pipe_q[2]) begin
      s3_d.mag = mag_sat;
      s3_d.edg = (mag_sat >= s2_q.th);
    end

    cnt_d = cnt_q;
    if (vld_pipe_q[STAGES]) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.mag_o   = s3_q.mag;
  assign bus.edge_o  = s3_q.edg;
  assign bus.valid_o = vld_pipe_q[STAGES];
  assign bus.done_o  = vld_pipe_q[STAGES] && (cnt_q == CNT_LAST);
endmodule

// File: tb/tb_sobel_gradient.sv
// Directed scoreboard bench for sobel_gradient: hand-computed windows, frame/done, bubbles, mid-frame reset.
module tb_sobel_gradient;
  import sobel_pkg::*;

  localparam int FRAME = 12;  // (5-2)*(6-2)

  typedef logic [8:0][7:0] win_t;
  typedef struct {
    win_t       w;
    logic [7:0] th;
    logic [7:0] mag;
    logic       edg;
  } vec_t;
  typedef struct {
    logic [7:0] mag;
    logic       edg;
    logic       done;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_gradient_if bus ();

  sobel_gradient #(.ROWS(5), .COLS(6), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t vecs[10];
  exp_t sbq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   n_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic win_t mkw(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win_t w;
    w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2);
    w[3] = 8'(a3); w[4] = 8'(a4); w[5] = 8'(a5);
    w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge, pop and compare whenever valid_o is up.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no output (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("mag", 32'(bus.mag_o), 32'(e.mag));
        check("edge", 32'(bus.edge_o), 32'(e.edg));
        check("done", 32'(bus.done_o), 32'(e.done));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("done_without_valid", 32'(bus.done_o), 32'd0);
    end
  end

  task automatic drive_win(input int i);
    bus.d0_i = vecs[i].w[0]; bus.d1_i = vecs[i].w[1]; bus.d2_i = vecs[i].w[2];
    bus.d3_i = vecs[i].w[3]; bus.d4_i = vecs[i].w[4]; bus.d5_i = vecs[i].w[5];
    bus.d6_i = vecs[i].w[6]; bus.d7_i = vecs[i].w[7]; bus.d8_i = vecs[i].w[8];
    bus.thresh_i = vecs[i].th;
  endtask

  task automatic send(input int i);
    exp_t e;
    @(posedge clk); #1;
    bus.valid_i = 1'b1;
    drive_win(i);
    e.mag  = vecs[i].mag;
    e.edg  = vecs[i].edg;
    e.done = (n_model == FRAME - 1);
    e.cyc  = cyc + 3;
    sbq.push_back(e);
    n_model = (n_model + 1) % FRAME;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
    end
  endtask

  // One-cycle reset; beats due after the reset edge are flushed, optionally with a window offered alongside.
  task automatic do_reset(input bit with_win);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.valid_i = with_win;
    if (with_win) drive_win(1);
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
    n_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(sbq.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{mkw(50, 50, 50, 50, 50, 50, 50, 50, 50), 8'd1,   8'd0,   1'b0};
    vecs[1] = '{mkw(1, 2, 3, 7, 8, 9, 13, 14, 15),       8'd56,  8'd56,  1'b1};
    vecs[2] = '{mkw(1, 2, 3, 7, 8, 9, 13, 14, 15),       8'd57,  8'd56,  1'b0};
    vecs[3] = '{mkw(0, 0, 255, 0, 0, 255, 0, 0, 255),    8'd255, 8'd255, 1'b1};
    vecs[4] = '{mkw(0, 0, 10, 0, 0, 0, 0, 0, 0),         8'd21,  8'd20,  1'b0};
    vecs[5] = '{mkw(255, 0, 0, 255, 0, 0, 255, 0, 0),    8'd0,   8'd255, 1'b1};
    vecs[6] = '{mkw(0, 0, 0, 0, 0, 0, 0, 20, 0),         8'd40,  8'd40,  1'b1};
    vecs[7] = '{mkw(30, 0, 0, 0, 0, 0, 0, 0, 0),         8'd100, 8'd60,  1'b0};
    vecs[8] = '{mkw(0, 0, 0, 0, 0, 64, 0, 63, 0),        8'd254, 8'd254, 1'b1};
    vecs[9] = '{mkw(0, 0, 0, 0, 0, 64, 0, 64, 0),        8'd255, 8'd255, 1'b1};

    rst = 1'b1;
    bus.valid_i = 1'b0;
    drive_win(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mag", 32'(bus.mag_o), 32'd0);
    check("reset_edge", 32'(bus.edge_o), 32'd0);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Isolated windows: value and latency per vector.
    for (int i = 0; i < 10; i++) begin
      send(i);
      idle(4);
    end
    drain();
    do_reset(1'b0);

    // Two back-to-back frames: done on the 12th and 24th beats.
    for (int k = 0; k < 2 * FRAME; k++) send(k % 10);
    idle(1);
    drain();

    // Bubbled frame: one window every other cycle.
    for (int k = 0; k < FRAME; k++) begin
      send((k + 5) % 10);
      idle(1);
    end
    drain();

    // Five windows, reset with two still in flight and a window offered during reset.
    for (int k = 0; k < 5; k++) send(k);
    do_reset(1'b1);
    idle(8);
    for (int k = 0; k < FRAME; k++) send((k + 3) % 10);
    idle(1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Pipelined Sobel operator stage that sits directly downstream of `sobel_data_buffer`. Each valid 3x3 window `d0..d8` from the buffer becomes one 8-bit gradient magnitude (|Gx|+|Gy|, saturated) plus a binary edge flag against a programmable threshold. The block counts emitted pixels and pulses `done_o` once a full frame of interior pixels, (ROWS-2)*(COLS-2), has been produced.

## Interface
- `ROWS`, 5, image height in pixels (>=3)
- `COLS`, 6, image width in pixels (>=3)
- `DATA_W`, 8, pixel width; internal widths below assume 8

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `valid_i`  in  1  window `d0..d8` valid this cycle
- `d0_i..d8_i`  in  8 each  window, row-major: d0 top-left, d4 centre, d8 bottom-right
- `thresh_i`  in  8  edge threshold, sampled with each window in stage 1
- `mag_o`  out  8  saturated gradient magnitude
- `edge_o`  out  1  1 when magnitude >= threshold
- `valid_o`  out  1  `mag_o`/`edge_o` valid
- `done_o`  out  1  one-cycle pulse with the last pixel of a frame

## Operation
- Stage 1, on `valid_i`: Gx = (d2 + 2·d5 + d8) − (d0 + 2·d3 + d6); Gy = (d6 + 2·d7 + d8) − (d0 + 2·d1 + d2). Both are signed 11-bit, range ±1020. Register them with the threshold.
- Stage 2: register |Gx| and |Gy|, each unsigned 10-bit, max 1020.
- Stage 3: sum = |Gx| + |Gy|, unsigned 11-bit, max 2040.
  - `mag_o` = 255 if sum > 255, else sum[7:0].
  - `edge_o` = (saturated mag >= stage-3 threshold).
- Valid bit travels a 3-deep shift register alongside the data. Bubbles (`valid_i`=0) propagate as `valid_o`=0.
- When `valid_o`=0, data registers hold their previous values. `mag_o`/`edge_o` are don't-care to consumers but must not be X after reset.
- Pixel counter, range 0 .. (ROWS-2)*(COLS-2)−1, width $clog2 of the frame count:
  - Increments on each output beat with `valid_o`=1.
  - On the beat where count = max: `done_o`=1 and the counter wraps to 0, ready for the next frame with no gap.
- No backpressure: the consumer must accept every `valid_o` beat.

## Timing
- Latency: exactly 3 cycles. A window presented with `valid_i` at edge N appears with `valid_o` at edge N+3.
- Throughput: one window per cycle, sustained indefinitely.
- Reset values: `mag_o`=0, `edge_o`=0, `valid_o`=0, `done_o`=0. The valid pipe and pixel counter clear to 0.
- Reset mid-frame flushes every in-flight beat. Nothing emerges after reset deasserts until new `valid_i`, and the counter restarts at 0.
- `rst` and `valid_i` high together: reset wins and the window is dropped.
- `thresh_i` changes take effect per window: each pixel uses the threshold sampled with its own window.
- `done_o` is only ever high together with `valid_o`.

## Structure
- Shared package `sobel_pkg`:
  - `PIX_W`=8, `GRAD_W`=11, `ABS_W`=10, `SUM_W`=11.
  - `PIX_MAX`=255.
  - function `frame_pixels(ROWS, COLS)`.
- One natural sub-module, `sobel_kernel3`: combinational Gx/Gy from 9 pixels, reused by later blocks (e.g. direction estimation).
- The pipeline registers and pixel counter live in `sobel_gradient`.

## Test plan
- Flat window, all pixels 50, one beat → 3 cycles later `valid_o`=1, `mag_o`=0, `edge_o`=0 with `thresh_i`=1.
- Window 1 2 3 / 7 8 9 / 13 14 15 (ramp image top-left) → Gx=8, Gy=48, `mag_o`=56. `edge_o`=1 at thresh 56, 0 at thresh 57.
- Vertical step: d0,d3,d6=0 and d2,d5,d8=255 → Gx=1020, `mag_o`=255 (saturated). Also d2=10, rest 0 → `mag_o`=20.
- ROWS=5, COLS=6: 12 back-to-back windows → 12 `valid_o` beats, `done_o` only on the 12th. Repeat the frame immediately → second `done_o` 12 beats later.
- Bubbled input (valid every other cycle) → outputs spaced identically, each 3 cycles after its input. Counter still reaches `done_o` after 12 beats.
- Assert `rst` after 5 of 12 windows with 2 in flight → no `valid_o` afterwards. A fresh 12-window frame → `done_o` on its 12th output, not its 7th.
